// File: rtl/inst_issue_queue.sv
// Instruction issue queue: circular FIFO between the fetch side and the pipeline's
// registered inst input, issuing one instruction per cycle or a NOP bubble.
module inst_issue_queue #(
    parameter int         DEPTH    = 4,
    parameter logic [7:0] NOP_INST = 8'h00
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [7:0]             in_inst,
    output logic                   in_ready,
    input  logic                   issue_hold,
    input  logic                   flush,
    output logic [7:0]             inst,
    output logic                   issue_valid,
    output logic [$clog2(DEPTH):0] occupancy,
    output logic [15:0]            issued_cnt
);

    localparam int              PW       = $clog2(DEPTH);
    localparam int              CW       = PW + 1;
    localparam logic [CW-1:0]   FULL_CNT = CW'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    inst_q, inst_d;
    logic          issue_valid_q, issue_valid_d;
    logic [15:0]   issued_cnt_q, issued_cnt_d;
    logic          push;
    logic          pop;

    // in_ready deliberately ignores issue_hold so a full queue never depends on the stall path.
    assign in_ready = (count_q != FULL_CNT) && !flush && rst;
    assign push     = in_valid && in_ready;
    assign pop      = (count_q != '0) && !issue_hold && !flush;

    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        inst_d        = pop ? mem_q[rd_ptr_q] : NOP_INST;
        issue_valid_d = pop;
        issued_cnt_d  = issued_cnt_q + {15'd0, pop};
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            inst_q        <= NOP_INST;
            issue_valid_q <= 1'b0;
            issued_cnt_q  <= 16'd0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            inst_q        <= inst_d;
            issue_valid_q <= issue_valid_d;
            issued_cnt_q  <= issued_cnt_d;
        end
    end

    // Storage is not reset; an entry is only read after the count shows it was written.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_inst;
    end

    assign inst        = inst_q;
    assign issue_valid = issue_valid_q;
    assign occupancy   = count_q;
    assign issued_cnt  = issued_cnt_q;

endmodule

// File: tb/tb_inst_issue_queue.sv
// Directed bench for inst_issue_queue: vector table for the basic flow plus
// hand-written stream, flush, async-reset and counter-wrap sequences.
module tb_inst_issue_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_inst;
    logic        in_ready;
    logic        issue_hold;
    logic        flush;
    logic [7:0]  inst;
    logic        issue_valid;
    logic [2:0]  occupancy;
    logic [15:0] issued_cnt;

    int n_vec = 0;
    int n_err = 0;

    inst_issue_queue #(.DEPTH(4), .NOP_INST(8'h00)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_inst(in_inst),
        .in_ready(in_ready), .issue_hold(issue_hold), .flush(flush),
        .inst(inst), .issue_valid(issue_valid), .occupancy(occupancy),
        .issued_cnt(issued_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        h;
        logic        f;
        logic        rdy;
        logic [7:0]  e_inst;
        logic        e_vld;
        logic [2:0]  e_occ;
        logic [15:0] e_cnt;
    } vec_t;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic h, input logic f);
        in_valid   = v;
        in_inst    = d;
        issue_hold = h;
        flush      = f;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [7:0] ei, input logic ev,
                           input logic [2:0] eo, input logic [15:0] ec);
        check({tag, ".inst"},  {8'd0, inst},        {8'd0, ei});
        check({tag, ".valid"}, {15'd0, issue_valid}, {15'd0, ev});
        check({tag, ".occ"},   {13'd0, occupancy},   {13'd0, eo});
        check({tag, ".cnt"},   issued_cnt,           ec);
    endtask

    vec_t        vecs [13];
    logic [15:0] exp_cnt;
    logic [7:0]  prev;

    initial begin
        // pass-through of 4B, then fill under hold, 5th offer (85) refused, drain in order
        vecs[0]  = '{1'b1, 8'h4B, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 3'd1, 16'd0};
        vecs[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h4B, 1'b1, 3'd0, 16'd1};
        vecs[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 3'd0, 16'd1};
        vecs[3]  = '{1'b1, 8'h41, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 3'd1, 16'd1};
        vecs[4]  = '{1'b1, 8'h52, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 3'd2, 16'd1};
        vecs[5]  = '{1'b1, 8'h63, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 3'd3, 16'd1};
        vecs[6]  = '{1'b1, 8'h74, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 3'd4, 16'd1};
        vecs[7]  = '{1'b1, 8'h85, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 3'd4, 16'd1};
        vecs[8]  = '{1'b1, 8'h85, 1'b0, 1'b0, 1'b0, 8'h41, 1'b1, 3'd3, 16'd2};
        vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h52, 1'b1, 3'd2, 16'd3};
        vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h63, 1'b1, 3'd1, 16'd4};
        vecs[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h74, 1'b1, 3'd0, 16'd5};
        vecs[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 3'd0, 16'd5};

        rst = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        #12;
        chk_out("reset", 8'h00, 1'b0, 3'd0, 16'd0);
        check("reset.in_ready", {15'd0, in_ready}, 16'd0);
        rst = 1'b1;
        #1;

        foreach (vecs[i]) begin
            drive(vecs[i].v, vecs[i].d, vecs[i].h, vecs[i].f);
            #1;
            check($sformatf("vec%0d.in_ready", i), {15'd0, in_ready}, {15'd0, vecs[i].rdy});
            tick();
            chk_out($sformatf("vec%0d", i), vecs[i].e_inst, vecs[i].e_vld, vecs[i].e_occ, vecs[i].e_cnt);
        end
        exp_cnt = 16'd5;

        // steady stream of 12 entries: occupancy stays 1, pointers wrap three times
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0);
            tick();
            if (i == 0) begin
                chk_out("stream0", 8'h00, 1'b0, 3'd1, exp_cnt);
            end else begin
                exp_cnt = exp_cnt + 16'd1;
                chk_out($sformatf("stream%0d", i), prev, 1'b1, 3'd1, exp_cnt);
            end
            prev = 8'h10 + 8'(i);
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        exp_cnt = exp_cnt + 16'd1;
        chk_out("stream_tail", 8'h1B, 1'b1, 3'd0, exp_cnt);

        // flush with three queued entries and a new offer on the same edge
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'hA1 + 8'(i), 1'b1, 1'b0);
            tick();
        end
        check("preflush.occ", {13'd0, occupancy}, 16'd3);
        drive(1'b1, 8'hA4, 1'b0, 1'b1);
        #1;
        check("flush.in_ready", {15'd0, in_ready}, 16'd0);
        tick();
        chk_out("flush", 8'h00, 1'b0, 3'd0, exp_cnt);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        chk_out("postflush", 8'h00, 1'b0, 3'd0, exp_cnt);
        drive(1'b1, 8'hB1, 1'b0, 1'b0);
        tick();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        exp_cnt = exp_cnt + 16'd1;
        chk_out("after_flush_issue", 8'hB1, 1'b1, 3'd0, exp_cnt);

        // async reset between edges while two entries remain and C1 is on inst
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'hC1 + 8'(i), 1'b1, 1'b0);
            tick();
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        exp_cnt = exp_cnt + 16'd1;
        chk_out("prereset", 8'hC1, 1'b1, 3'd2, exp_cnt);
        issue_hold = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        chk_out("async_reset", 8'h00, 1'b0, 3'd0, 16'd0);
        check("async_reset.in_ready", {15'd0, in_ready}, 16'd0);
        @(negedge clk);
        rst = 1'b1;
        issue_hold = 1'b0;
        #1;
        check("post_reset.in_ready", {15'd0, in_ready}, 16'd1);
        tick();
        chk_out("post_reset", 8'h00, 1'b0, 3'd0, 16'd0);
        drive(1'b1, 8'hD1, 1'b0, 1'b0);
        tick();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        exp_cnt = 16'd1;
        chk_out("post_reset_issue", 8'hD1, 1'b1, 3'd0, exp_cnt);

        // issued_cnt wrap: stream until 16'hFFFF issues, then one more
        for (int i = 0; i < 65534; i++) begin
            drive(1'b1, 8'(i), 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        chk_out("cnt_ffff", 8'hFD, 1'b1, 3'd0, 16'hFFFF);
        drive(1'b1, 8'hE7, 1'b0, 1'b0);
        tick();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        chk_out("cnt_wrap", 8'hE7, 1'b1, 3'd0, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
